// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// The permutation sits ahead of the first register; a valid/ready chain with a tag rides alongside.
module shift_rows_pipe #(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_data,
    input  logic                in_inv,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                busy,
    output logic [15:0]         blk_cnt
);

    localparam int DW = 32 * NB;
    localparam int RW = 8 * NB;

    // Rijndael row offsets: Nb=8 uses 0,1,3,4; narrower blocks use 0,1,2,3.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2)
            return r + 1;
        return r;
    endfunction

    // Each row is an NB-byte vector with column c in byte c; forward is a
    // byte rotate right by the row offset, inverse a rotate left.
    function automatic logic [DW-1:0] shift_rows(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] res;
        logic [RW-1:0] row;
        int            s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            row = d[r*RW +: RW];
            s   = 8 * row_off(r);
            if (inv)
                row = (row << s) | (row >> (RW - s));
            else
                row = (row >> s) | (row << (RW - s));
            res[r*RW +: RW] = row;
        end
        return res;
    endfunction

    logic [DW-1:0]          shifted_p0;
    logic [DW-1:0]          data_p [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_p  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld_p;
    logic [PIPE_STAGES:0]   stg_free;
    logic [15:0]            cnt_q;

    assign shifted_p0 = shift_rows(in_data, in_inv);

    // stg_free[i]: stage i may load this cycle (empty, or its block moves on).
    always_comb begin
        stg_free              = '0;
        stg_free[PIPE_STAGES] = out_ready;
        for (int i = PIPE_STAGES - 1; i >= 0; i--)
            stg_free[i] = !vld_p[i] || stg_free[i+1];
    end

    assign in_ready  = !flush && stg_free[0];
    assign out_valid = vld_p[PIPE_STAGES-1];
    assign out_data  = data_p[PIPE_STAGES-1];
    assign out_tag   = tag_p[PIPE_STAGES-1];
    assign busy      = |vld_p;
    assign blk_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            cnt_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                data_p[i] <= '0;
                tag_p[i]  <= '0;
            end
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            if (out_valid && out_ready)
                cnt_q <= cnt_q + 16'd1;
            // p0 -> p1: capture the permuted block
            if (stg_free[0]) begin
                vld_p[0] <= in_valid;
                if (in_valid) begin
                    data_p[0] <= shifted_p0;
                    tag_p[0]  <= in_tag;
                end
            end
            // p1 -> p2 and beyond: data only moves with a valid block
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (stg_free[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    if (vld_p[i-1]) begin
                        data_p[i] <= data_p[i-1];
                        tag_p[i]  <= tag_p[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: an NB=4/1-stage and an NB=8/2-stage instance,
// directed vectors plus a per-cycle scoreboard built from the row/offset rules.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_flush = 0, a_in_valid = 0, a_in_inv = 0, a_out_ready = 1;
    logic [127:0] a_in_data = '0;
    logic [3:0]   a_in_tag = '0;
    logic         a_in_ready, a_out_valid, a_busy;
    logic [127:0] a_out_data;
    logic [3:0]   a_out_tag;
    logic [15:0]  a_blk_cnt;

    logic         b_flush = 0, b_in_valid = 0, b_in_inv = 0, b_out_ready = 1;
    logic [255:0] b_in_data = '0;
    logic [3:0]   b_in_tag = '0;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [255:0] b_out_data;
    logic [3:0]   b_out_tag;
    logic [15:0]  b_blk_cnt;

    shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_inv(a_in_inv), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag), .busy(a_busy),
        .blk_cnt(a_blk_cnt));

    shift_rows_pipe #(.NB(8), .PIPE_STAGES(2), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy),
        .blk_cnt(b_blk_cnt));

    localparam logic [127:0] D0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] F0 = 128'h0E0D0C0F_09080B0A_04070605_03020100;
    localparam logic [255:0] B8 = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
    localparam logic [255:0] F8 = 256'h1B1A19181F1E1D1C_1211101716151413_080F0E0D0C0B0A09_0706050403020100;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Row r, column c lives in byte r*nb+c; out(r,c) = in(r, c +/- offset mod nb).
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit inv);
        logic [255:0] res;
        int off, src;
        res = '0;
        for (int row = 0; row < 4; row++) begin
            off = (nb == 8 && row >= 2) ? row + 1 : row;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - off + nb) % nb : (c + off) % nb;
                res[8*(row*nb+c) +: 8] = d[8*(row*nb+src) +: 8];
            end
        end
        return res;
    endfunction

    typedef struct {
        logic [255:0] data;
        logic [3:0]   tag;
        int           acc;
    } exp_t;

    exp_t         sb [2][$];
    int           last_out [2] = '{-100, -100};
    logic [15:0]  bc_m [2] = '{16'd0, 16'd0};
    bit           prev_hold [2] = '{0, 0};
    logic [255:0] prev_data [2];
    logic [3:0]   prev_tag [2];

    task automatic mon(input int d, input int nb, input int s,
                       input logic iv, input logic ir, input logic [255:0] idat,
                       input logic iinv, input logic [3:0] itag,
                       input logic ov, input logic ordy, input logic [255:0] odat,
                       input logic [3:0] otag, input logic [15:0] bc,
                       input logic fl, input logic bsy);
        bit   exp_v, exp_r;
        exp_t e;
        exp_v = 0;
        if (sb[d].size() > 0)
            exp_v = (cyc >= sb[d][0].acc + s) && (cyc >= last_out[d] + 1);
        exp_r = !fl && !(sb[d].size() == s && !ordy);
        check($sformatf("out_valid[%0d]", d), ov, exp_v);
        if (exp_v) begin
            check($sformatf("out_data[%0d]", d), odat, sb[d][0].data);
            check($sformatf("out_tag[%0d]", d), otag, sb[d][0].tag);
        end
        check($sformatf("busy[%0d]", d), bsy, sb[d].size() > 0);
        check($sformatf("in_ready[%0d]", d), ir, exp_r);
        check($sformatf("blk_cnt[%0d]", d), bc, bc_m[d]);
        if (prev_hold[d]) begin
            check($sformatf("hold_data[%0d]", d), odat, prev_data[d]);
            check($sformatf("hold_tag[%0d]", d), otag, prev_tag[d]);
        end
        if (exp_v && ordy) begin
            void'(sb[d].pop_front());
            last_out[d] = cyc;
            if (!fl) bc_m[d] = bc_m[d] + 16'd1;
        end
        if (iv && exp_r) begin
            e.data = ref_shift(nb, idat, iinv);
            e.tag  = itag;
            e.acc  = cyc;
            sb[d].push_back(e);
        end
        if (fl) sb[d].delete();
        prev_hold[d] = (ov && !ordy) || fl;
        prev_data[d] = odat;
        prev_tag[d]  = otag;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                sb[d].delete();
                bc_m[d] = '0;
                last_out[d] = -100;
                prev_hold[d] = 0;
            end
        end else begin
            mon(0, 4, 1, a_in_valid, a_in_ready, {128'd0, a_in_data}, a_in_inv, a_in_tag,
                a_out_valid, a_out_ready, {128'd0, a_out_data}, a_out_tag, a_blk_cnt, a_flush, a_busy);
            mon(1, 8, 2, b_in_valid, b_in_ready, b_in_data, b_in_inv, b_in_tag,
                b_out_valid, b_out_ready, b_out_data, b_out_tag, b_blk_cnt, b_flush, b_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int sent, base, bc0;
        bit took;
        repeat (3) step();
        rst_n = 1'b1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_tag", a_out_tag, 0);
        check("rst_blk_cnt", a_blk_cnt, 0);
        check("rst_busy", a_busy, 0);
        check("rst_in_ready_a", a_in_ready, 1);
        check("rst_in_ready_b", b_in_ready, 1);
        check("rst_out_valid_b", b_out_valid, 0);

        check("model_fwd4", ref_shift(4, {128'd0, D0}, 0), {128'd0, F0});
        check("model_inv4", ref_shift(4, {128'd0, F0}, 1), {128'd0, D0});
        check("model_fwd8", ref_shift(8, B8, 0), F8);
        check("model_inv8", ref_shift(8, F8, 1), B8);

        // NB=4 forward then inverse, one-cycle latency
        a_in_valid = 1; a_in_data = D0; a_in_inv = 0; a_in_tag = 4'd3;
        step();
        check("fwd4_valid", a_out_valid, 1);
        check("fwd4_data", a_out_data, F0);
        check("fwd4_tag", a_out_tag, 4'd3);
        a_in_data = F0; a_in_inv = 1; a_in_tag = 4'd5;
        step();
        check("fwd4_blk_cnt", a_blk_cnt, 16'd1);
        check("inv4_data", a_out_data, D0);
        check("inv4_tag", a_out_tag, 4'd5);
        for (int i = 0; i < 6; i++) begin
            a_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            a_in_inv = i[0];
            a_in_tag = i[3:0];
            step();
        end
        a_in_valid = 0;
        step(); step();
        check("mixed_blk_cnt", a_blk_cnt, 16'd8);

        // NB=8 forward, two-stage latency
        b_out_ready = 1; b_in_valid = 1; b_in_data = B8; b_in_inv = 0; b_in_tag = 4'd7;
        step();
        b_in_valid = 0;
        check("fwd8_lat1_valid", b_out_valid, 0);
        step();
        check("fwd8_valid", b_out_valid, 1);
        check("fwd8_data", b_out_data, F8);
        check("fwd8_tag", b_out_tag, 4'd7);
        step();
        check("fwd8_blk_cnt", b_blk_cnt, 16'd1);

        // ten blocks with out_ready pattern 1,0,0,1
        base = b_blk_cnt;
        sent = 0;
        took = 1;
        for (int k = 0; k < 80 && (sent < 10 || b_busy); k++) begin
            b_out_ready = (k % 4 == 0) || (k % 4 == 3);
            b_in_valid = (sent < 10);
            if (took)
                b_in_data = {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
            b_in_tag = sent[3:0];
            b_in_inv = sent[0];
            #2;
            took = b_in_valid && b_in_ready;
            if (took) sent++;
            step();
        end
        b_in_valid = 0;
        check("stream_sent", sent, 10);
        check("stream_blk_cnt", b_blk_cnt, 16'(base + 10));
        check("stream_sb_empty", sb[1].size(), 0);

        // fill the pipe, then flush while a transfer is also happening
        b_out_ready = 0; b_in_valid = 1; b_in_tag = 4'd1;
        step();
        b_in_tag = 4'd2;
        step();
        b_in_tag = 4'd3;
        #1;
        check("full_in_ready", b_in_ready, 0);
        check("full_busy", b_busy, 1);
        bc0 = b_blk_cnt;
        b_flush = 1; b_out_ready = 1; b_in_tag = 4'd4;
        #1;
        check("flush_in_ready", b_in_ready, 0);
        step();
        b_flush = 0; b_in_valid = 0;
        check("flush_out_valid", b_out_valid, 0);
        check("flush_busy", b_busy, 0);
        check("flush_blk_cnt", b_blk_cnt, 16'(bc0));
        step(); step();
        check("flush_no_accept", b_out_valid, 0);

        // asynchronous reset mid-stream
        a_in_valid = 1; a_out_ready = 1; a_in_tag = 4'd9; a_in_data = D0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_out_data", a_out_data, 0);
        check("arst_out_tag", a_out_tag, 0);
        check("arst_blk_cnt", a_blk_cnt, 0);
        check("arst_busy", a_busy, 0);
        check("arst_blk_cnt_b", b_blk_cnt, 0);
        a_in_valid = 0;
        step();
        rst_n = 1'b1;
        check("arst_rel_in_ready", a_in_ready, 1);
        check("arst_rel_out_valid", a_out_valid, 0);
        check("arst_rel_blk_cnt", a_blk_cnt, 0);
        step();

        // blk_cnt wrap
        a_in_valid = 1; a_in_inv = 0; a_in_data = D0;
        for (int k = 0; k < 70000 && a_blk_cnt != 16'hFFFF; k++) step();
        check("wrap_reach_ffff", a_blk_cnt, 16'hFFFF);
        step();
        check("wrap_zero", a_blk_cnt, 16'h0000);
        a_in_valid = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
